// File: rtl/util_axis_seq_checker.sv
// AXI-Stream sink that checks received data forms an incrementing counter sequence.
// Define RANDOM_READY_EN to add LFSR-driven pseudo-random backpressure on s_axis_tready.
module util_axis_seq_checker #(
  parameter int unsigned BUS_WIDTH   = 1,
  parameter int unsigned COUNT_WIDTH = 16,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                     aclk,
  input  logic                     arst,
  input  logic                     enable,
  input  logic                     clear,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [8*BUS_WIDTH-1:0]   s_axis_tdata,
  output logic [COUNT_WIDTH-1:0]   beat_count,
  output logic [COUNT_WIDTH-1:0]   error_count,
  output logic                     mismatch,
  output logic                     error_sticky
);

  localparam int unsigned DataWidth = 8 * BUS_WIDTH;

  typedef enum logic [1:0] {StIdle, StSync, StCheck} state_e;

  state_e                 state_q, state_d;
  logic [DataWidth-1:0]   expected_q, expected_d;
  logic [COUNT_WIDTH-1:0] beat_q, beat_d;
  logic [COUNT_WIDTH-1:0] err_q, err_d;
  logic                   mismatch_q, mismatch_d;
  logic                   sticky_q, sticky_d;
  logic                   running;
  logic                   accept;
  logic                   bad_beat;

  assign running = (state_q != StIdle);

`ifdef RANDOM_READY_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR, taps 16,14,13,11; free-running out of reset
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign s_axis_tready = running && lfsr_q[0];
`else
  logic unused_seed;
  assign unused_seed   = ^LFSR_SEED;
  assign s_axis_tready = running;
`endif

  assign accept   = s_axis_tvalid && s_axis_tready;
  assign bad_beat = accept && (state_q == StCheck) && (s_axis_tdata != expected_q);

  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    beat_d     = beat_q;
    err_d      = err_q;
    sticky_d   = sticky_q;
    mismatch_d = bad_beat;

    unique case (state_q)
      StIdle:  if (enable) state_d = StSync;
      StSync: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (accept) begin
          state_d = StCheck;
        end
      end
      StCheck: if (!enable) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // On a match tdata+1 equals expected+1; on a mismatch it resyncs to the new data.
    if (accept) begin
      expected_d = s_axis_tdata + 1'b1;
      if (beat_q != '1) beat_d = beat_q + 1'b1;
    end

    if (bad_beat) begin
      if (err_q != '1) err_d = err_q + 1'b1;
      sticky_d = 1'b1;
    end

    // clear overrides counter/flag updates but not the FSM or expected value
    if (clear) begin
      beat_d     = '0;
      err_d      = '0;
      sticky_d   = 1'b0;
      mismatch_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state_q    <= StIdle;
      expected_q <= '0;
      beat_q     <= '0;
      err_q      <= '0;
      mismatch_q <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      beat_q     <= beat_d;
      err_q      <= err_d;
      mismatch_q <= mismatch_d;
      sticky_q   <= sticky_d;
    end
  end

  assign beat_count   = beat_q;
  assign error_count  = err_q;
  assign mismatch     = mismatch_q;
  assign error_sticky = sticky_q;

endmodule

// File: doc/util_axis_seq_checker.md
# util_axis_seq_checker

Synthesizable AXI-Stream sink that consumes the master side of a stream buffer such as util_axis_xfifo. It applies optional pseudo-random backpressure and checks that the received data forms an incrementing counter sequence. It reports beat and error counts for on-chip or bench verification of FIFO ordering and integrity. It is the consumer-side counterpart to an incrementing-counter stream source.

## Interface
- BUS_WIDTH, 1, tdata width in bytes; data width is 8*BUS_WIDTH
- COUNT_WIDTH, 16, width of the beat and error counters
- LFSR_SEED, 16'hACE1, reset value of the backpressure LFSR; must be nonzero
- aclk  input  1  clock for all logic
- arst  input  1  asynchronous, active-high reset
- enable  input  1  checker runs while high
- clear  input  1  synchronous clear of counters and sticky error
- s_axis_tvalid  input  1  stream valid
- s_axis_tready  output  1  stream ready
- s_axis_tdata  input  8*BUS_WIDTH  stream data
- beat_count  output  COUNT_WIDTH  accepted beats, saturating
- error_count  output  COUNT_WIDTH  sequence mismatches, saturating
- mismatch  output  1  one-cycle pulse per mismatched beat
- error_sticky  output  1  set on first mismatch, held until clear or reset

## Operation
- Beat accepted when s_axis_tvalid && s_axis_tready at the rising edge of aclk.
- FSM states:
  - IDLE: tready=0. Go to SYNC when enable=1.
  - SYNC: first accepted beat loads expected = tdata+1. No compare is done. beat_count increments. Go to CHECK.
  - CHECK: each accepted beat is compared with expected.
    - Equal: expected <= expected+1.
    - Not equal: mismatch pulses, error_count increments, error_sticky sets, and expected <= tdata+1 (resync, so one corrupted beat counts as exactly one error).
    - beat_count increments on every accepted beat.
- From SYNC or CHECK, enable=0 returns to IDLE. Counters hold. Re-enable goes through SYNC again.
- Arithmetic:
  - expected wraps modulo 2^(8*BUS_WIDTH); a transition from all-ones to 0 is a match.
  - Counters saturate at all-ones and never wrap.
- clear and an accepted beat in the same cycle: clear wins. Counters become 0, error_sticky becomes 0, mismatch becomes 0. The FSM and expected still update from that beat.
- Reset mid-stream: immediate return to IDLE. tready drops asynchronously. All state reinitializes.

## Timing
- Reset values:
  - s_axis_tready=0, beat_count=0, error_count=0, mismatch=0, error_sticky=0
  - state=IDLE, expected=0, LFSR=LFSR_SEED
- Register timing:
  - tready is driven from registered state only, with no combinational path from tvalid.
  - tready rises the cycle after enable is sampled high.
  - tready falls the cycle after enable is sampled low.
- Output latency:
  - beat_count, error_count, error_sticky and mismatch update on the edge that accepts the beat, visible 1 cycle after acceptance.
  - mismatch is high for exactly one cycle per bad beat; back-to-back bad beats give continuous high.
- Throughput: 1 beat/cycle when tready is held high.
- Data is sampled only on acceptance; tdata when tvalid=0 or tready=0 is ignored.

## Configuration
- Macro RANDOM_READY_EN.
- Defined:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, advancing every cycle out of reset.
  - s_axis_tready = (state != IDLE) && lfsr[0].
- Undefined:
  - LFSR is not built.
  - s_axis_tready = (state != IDLE), constant high while running.

## Test plan
- Macro undefined: reset, enable=1, drive tvalid=1 with data 0..299 (BUS_WIDTH=1, wrapping past 255) -> beat_count=300, error_count=0, error_sticky=0, tready high continuously from the cycle after enable.
- Sequence 5,6,7,9,10,11 -> exactly one mismatch pulse on the beat carrying 9, error_count=1, no further errors (resync verified).
- Macro defined: source toggles tvalid every cycle, checker applies random tready, 1000 incrementing beats -> beat_count=1000, error_count=0, and at least one tready=0 cycle while tvalid=1.
- Start stream at 0x80 -> SYNC accepts without error. Drive 300 corrupt beats with COUNT_WIDTH=8 -> error_count saturates at 255, beat_count saturates at 255.
- Mid-stream enable=0 for 10 cycles, then resume with a discontinuous value 0x40 -> tready=0 during the gap, counters held, no error on 0x40 (re-SYNC).
- Assert clear together with a mismatching beat -> error_count=0, error_sticky=0, mismatch=0. Assert arst mid-stream -> tready=0 immediately and all outputs at reset values.
